// File: rtl/rv64g_operand_fetch.sv
// -----------------------------------------------------------------------------
// rv64g_operand_fetch
// Issue / operand-fetch stage in front of the register file read and lock
// ports. Holds one decoded instruction, checks its sources and destination
// against the regfile lock vector, bypasses same-cycle writeback data, locks
// the destination when it issues and presents a registered bundle to execute.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  drop the held instruction and the output bundle
//   dec_valid_i/dec_ready_o  decode handshake
//   dec_payload_i            opaque payload, passed through unchanged
//   dec_rs_addr_i            rs1 in [AW-1:0], rs2 in [2*AW-1:AW], rs3 on top
//   dec_rs_use_i             per-source use flags (bit 0 = rs1)
//   dec_rd_addr_i/_we_i      destination register and its write enable
//   locks_i                  per-register pending-write locks from the regfile
//   rsN_addr_o/rsN_data_i    combinational regfile read ports
//   wb_en_i/_addr_i/_data_i  copy of the regfile unlock/writeback port
//   wr_lock_en_o/_addr_o     destination lock request in the issue cycle
//   ex_*                     registered bundle to execute (valid/ready)
//   stall_cnt_o              saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module rv64g_operand_fetch #(
  parameter int  NUM_REGS  = 64,
  parameter int  XLEN      = 64,
  parameter int  PAYLOAD_W = 64,
  parameter int  CNT_W     = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [PAYLOAD_W-1:0] dec_payload_i,
  input  logic [3*AW-1:0]      dec_rs_addr_i,
  input  logic [2:0]           dec_rs_use_i,
  input  logic [AW-1:0]        dec_rd_addr_i,
  input  logic                 dec_rd_we_i,
  input  logic [NUM_REGS-1:0]  locks_i,
  output logic [AW-1:0]        rs1_addr_o,
  output logic [AW-1:0]        rs2_addr_o,
  output logic [AW-1:0]        rs3_addr_o,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  input  logic [XLEN-1:0]      rs3_data_i,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic                 wr_lock_en_o,
  output logic [AW-1:0]        wr_lock_addr_o,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [PAYLOAD_W-1:0] ex_payload_o,
  output logic [XLEN-1:0]      ex_rs1_data_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [XLEN-1:0]      ex_rs3_data_o,
  output logic [AW-1:0]        ex_rd_addr_o,
  output logic                 ex_rd_we_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   hold_payload_q;
  logic [3*AW-1:0]        hold_rs_addr_q;
  logic [2:0]             hold_rs_use_q;
  logic [AW-1:0]          hold_rd_addr_q;
  logic                   hold_rd_we_q;

  logic                   ex_valid_q;
  logic [PAYLOAD_W-1:0]   ex_payload_q;
  logic [XLEN-1:0]        ex_op_q [3];
  logic [AW-1:0]          ex_rd_addr_q;
  logic                   ex_rd_we_q;
  logic [CNT_W-1:0]       stall_cnt_q;

  logic [AW-1:0]          src_addr_s  [3];
  logic [XLEN-1:0]        src_rdata_s [3];
  logic [XLEN-1:0]        src_op_s    [3];
  logic [2:0]             src_hit_s;
  logic [2:0]             src_clear_s;
  logic                   rd_hit_s;
  logic                   rd_clear_s;
  logic                   issue_s;
  logic                   lock_s;
  logic                   accept_s;

  assign src_rdata_s[0] = rs1_data_i;
  assign src_rdata_s[1] = rs2_data_i;
  assign src_rdata_s[2] = rs3_data_i;

  // Per-source read address, hazard-clear flag and operand with writeback bypass
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      if (state_q == ST_HELD) begin
        src_addr_s[n] = hold_rs_addr_q[n*AW +: AW];
      end else begin
        src_addr_s[n] = {AW{1'b0}};
      end
      src_hit_s[n]   = wb_en_i && (wb_addr_i == src_addr_s[n]);
      src_clear_s[n] = !hold_rs_use_q[n] || (src_addr_s[n] == {AW{1'b0}}) ||
                       !locks_i[src_addr_s[n]] || src_hit_s[n];
      if (!hold_rs_use_q[n] || (src_addr_s[n] == {AW{1'b0}})) begin
        src_op_s[n] = {XLEN{1'b0}};
      end else if (src_hit_s[n]) begin
        src_op_s[n] = wb_data_i;
      end else begin
        src_op_s[n] = src_rdata_s[n];
      end
    end
  end

  // A writeback to rd this cycle releases the WAW hazard; the new lock wins in the regfile
  assign rd_hit_s   = wb_en_i && (wb_addr_i == hold_rd_addr_q);
  assign rd_clear_s = !hold_rd_we_q || (hold_rd_addr_q == {AW{1'b0}}) ||
                      !locks_i[hold_rd_addr_q] || rd_hit_s;

  assign issue_s  = !rst_i && !flush_i && (state_q == ST_HELD) && (&src_clear_s) &&
                    rd_clear_s && (!ex_valid_q || ex_ready_i);
  assign lock_s   = issue_s && hold_rd_we_q && (hold_rd_addr_q != {AW{1'b0}});
  assign accept_s = dec_valid_i && dec_ready_o;

  // Hold FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold FSM next state: an issue frees the slot unless a new bundle refills it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = ST_HELD;
        else          state_d = ST_EMPTY;
      end
      ST_HELD: begin
        if (flush_i)       state_d = ST_EMPTY;
        else if (issue_s)  state_d = accept_s ? ST_HELD : ST_EMPTY;
        else               state_d = ST_HELD;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Hold FSM outputs: decode ready, destination lock request and read addresses
  always_comb begin
    dec_ready_o = !rst_i && !flush_i && ((state_q == ST_EMPTY) || issue_s);
    if (lock_s) begin
      wr_lock_en_o   = 1'b1;
      wr_lock_addr_o = hold_rd_addr_q;
    end else begin
      wr_lock_en_o   = 1'b0;
      wr_lock_addr_o = {AW{1'b0}};
    end
    rs1_addr_o = src_addr_s[0];
    rs2_addr_o = src_addr_s[1];
    rs3_addr_o = src_addr_s[2];
  end

  // Capture the decoded instruction when it is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_payload_q <= {PAYLOAD_W{1'b0}};
      hold_rs_addr_q <= {(3*AW){1'b0}};
      hold_rs_use_q  <= 3'b000;
      hold_rd_addr_q <= {AW{1'b0}};
      hold_rd_we_q   <= 1'b0;
    end else if (accept_s) begin
      hold_payload_q <= dec_payload_i;
      hold_rs_addr_q <= dec_rs_addr_i;
      hold_rs_use_q  <= dec_rs_use_i;
      hold_rd_addr_q <= dec_rd_addr_i;
      hold_rd_we_q   <= dec_rd_we_i;
    end else begin
      hold_payload_q <= hold_payload_q;
    end
  end

  // Execute-side output register; data is only replaced on issue so it stays stable under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q   <= 1'b0;
      ex_payload_q <= {PAYLOAD_W{1'b0}};
      ex_op_q[0]   <= {XLEN{1'b0}};
      ex_op_q[1]   <= {XLEN{1'b0}};
      ex_op_q[2]   <= {XLEN{1'b0}};
      ex_rd_addr_q <= {AW{1'b0}};
      ex_rd_we_q   <= 1'b0;
    end else if (issue_s) begin
      ex_valid_q   <= 1'b1;
      ex_payload_q <= hold_payload_q;
      ex_op_q[0]   <= src_op_s[0];
      ex_op_q[1]   <= src_op_s[1];
      ex_op_q[2]   <= src_op_s[2];
      ex_rd_addr_q <= hold_rd_addr_q;
      ex_rd_we_q   <= hold_rd_we_q;
    end else if (flush_i || (ex_valid_q && ex_ready_i)) begin
      ex_valid_q   <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_q;
    end
  end

  // Hazard-stall counter; a flush cycle is not a hazard stall and is not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else if ((state_q == ST_HELD) && !issue_s && !flush_i &&
                 (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_payload_o  = ex_payload_q;
  assign ex_rs1_data_o = ex_op_q[0];
  assign ex_rs2_data_o = ex_op_q[1];
  assign ex_rs3_data_o = ex_op_q[2];
  assign ex_rd_addr_o  = ex_rd_addr_q;
  assign ex_rd_we_o    = ex_rd_we_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_rv64g_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_rv64g_operand_fetch
// Directed scenarios followed by a randomized run. The bench plays decode,
// execute and the register file (data array plus lock vector) and predicts
// every output from an instruction-level model of the stage.
// -----------------------------------------------------------------------------
module tb_rv64g_operand_fetch;
  localparam int NR = 64;
  localparam int XL = 64;
  localparam int PW = 64;
  localparam int CW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, dec_valid, dec_ready, dec_rd_we;
  logic [PW-1:0] dec_payload;
  logic [3*AW-1:0] dec_rs_addr;
  logic [2:0]    dec_rs_use;
  logic [AW-1:0] dec_rd_addr;
  logic [NR-1:0] lk;
  logic [AW-1:0] rs1_addr, rs2_addr, rs3_addr;
  logic [XL-1:0] rs1_data, rs2_data, rs3_data;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [XL-1:0] wb_data;
  logic          wr_lock_en;
  logic [AW-1:0] wr_lock_addr;
  logic          ex_valid, ex_ready, ex_rd_we;
  logic [PW-1:0] ex_payload;
  logic [XL-1:0] ex_rs1, ex_rs2, ex_rs3;
  logic [AW-1:0] ex_rd_addr;
  logic [CW-1:0] stall_cnt;

  logic [XL-1:0] regs [NR];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign rs3_data = regs[rs3_addr];

  rv64g_operand_fetch #(.NUM_REGS(NR), .XLEN(XL), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_payload_i(dec_payload),
    .dec_rs_addr_i(dec_rs_addr), .dec_rs_use_i(dec_rs_use),
    .dec_rd_addr_i(dec_rd_addr), .dec_rd_we_i(dec_rd_we), .locks_i(lk),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rs3_addr_o(rs3_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .rs3_data_i(rs3_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .wr_lock_en_o(wr_lock_en), .wr_lock_addr_o(wr_lock_addr),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_payload_o(ex_payload),
    .ex_rs1_data_o(ex_rs1), .ex_rs2_data_o(ex_rs2), .ex_rs3_data_o(ex_rs3),
    .ex_rd_addr_o(ex_rd_addr), .ex_rd_we_o(ex_rd_we), .stall_cnt_o(stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one waiting instruction, one execute bundle, a counter
  logic          m_hv;
  logic [PW-1:0] m_hpay;
  logic [AW-1:0] m_hrs [3];
  logic [2:0]    m_huse;
  logic [AW-1:0] m_hrd;
  logic          m_hwe;
  logic          m_ev;
  logic [PW-1:0] m_epay;
  logic [XL-1:0] m_eop [3];
  logic [AW-1:0] m_erd;
  logic          m_ewe;
  logic [CW-1:0] m_cnt;
  logic          m_issue, m_rdy, m_lken;
  logic [AW-1:0] m_lkaddr;
  logic [AW-1:0] m_ad [3];
  logic [XL-1:0] m_op [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic wb_hits(input logic [AW-1:0] a);
    return wb_en && (wb_addr == a);
  endfunction

  // What the stage should do this cycle, from the waiting instruction and the inputs
  task automatic model_comb();
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < 3; n++) begin
      m_ad[n] = m_hv ? m_hrs[n] : 6'd0;
      if (!m_huse[n] || m_ad[n] == 6'd0) m_op[n] = 64'd0;
      else if (wb_hits(m_ad[n]))          m_op[n] = wb_data;
      else                                m_op[n] = regs[m_ad[n]];
      if (m_huse[n] && m_ad[n] != 6'd0 && lk[m_ad[n]] && !wb_hits(m_ad[n])) ok = 1'b0;
    end
    if (m_hwe && m_hrd != 6'd0 && lk[m_hrd] && !wb_hits(m_hrd)) ok = 1'b0;
    m_issue  = !rst && !flush && m_hv && ok && (!m_ev || ex_ready);
    m_rdy    = !rst && !flush && (!m_hv || m_issue);
    m_lken   = m_issue && m_hwe && (m_hrd != 6'd0);
    m_lkaddr = m_lken ? m_hrd : 6'd0;
  endtask

  // Clock-edge update of the model and of the emulated regfile lock vector
  task automatic model_seq();
    if (rst) begin
      m_hv = 1'b0; m_ev = 1'b0; m_epay = 64'd0; m_erd = 6'd0; m_ewe = 1'b0;
      for (int n = 0; n < 3; n++) m_eop[n] = 64'd0;
      m_cnt = 32'd0;
      lk = 64'd0;
    end else begin
      if (m_hv && !m_issue && !flush && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 32'd1;
      if (m_issue) begin
        m_ev = 1'b1; m_epay = m_hpay; m_erd = m_hrd; m_ewe = m_hwe;
        for (int n = 0; n < 3; n++) m_eop[n] = m_op[n];
      end else if (flush || (m_ev && ex_ready)) begin
        m_ev = 1'b0;
      end
      if (dec_valid && m_rdy) begin
        m_hv = 1'b1; m_hpay = dec_payload; m_huse = dec_rs_use;
        m_hrd = dec_rd_addr; m_hwe = dec_rd_we;
        for (int n = 0; n < 3; n++) m_hrs[n] = dec_rs_addr[n*AW +: AW];
      end else if (m_issue || flush) begin
        m_hv = 1'b0;
      end
      if (wb_en)  lk[wb_addr]  = 1'b0;
      if (m_lken) lk[m_lkaddr] = 1'b1;
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registered outputs
  task automatic tick();
    #1;
    model_comb();
    chk("dec_ready", dec_ready, m_rdy);
    chk("wr_lock_en", wr_lock_en, m_lken);
    chk("wr_lock_addr", wr_lock_addr, m_lkaddr);
    if (!rst) begin
      chk("rs1_addr", rs1_addr, m_ad[0]);
      chk("rs2_addr", rs2_addr, m_ad[1]);
      chk("rs3_addr", rs3_addr, m_ad[2]);
    end
    @(posedge clk);
    #1;
    model_seq();
    chk("ex_valid", ex_valid, m_ev);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_ev) begin
      chk("ex_payload", ex_payload, m_epay);
      chk("ex_rs1", ex_rs1, m_eop[0]);
      chk("ex_rs2", ex_rs2, m_eop[1]);
      chk("ex_rs3", ex_rs3, m_eop[2]);
      chk("ex_rd_addr", ex_rd_addr, m_erd);
      chk("ex_rd_we", ex_rd_we, m_ewe);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] pay, input logic [5:0] r1, input logic [5:0] r2,
                      input logic [5:0] r3, input logic [2:0] use_f, input logic [5:0] rd,
                      input logic we);
    dec_valid = 1'b1; dec_payload = pay; dec_rs_addr = {r3, r2, r1};
    dec_rs_use = use_f; dec_rd_addr = rd; dec_rd_we = we;
  endtask

  task automatic idle();
    dec_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rand_inputs();
    rst         = ($urandom_range(0, 299) == 0);
    flush       = ($urandom_range(0, 24) == 0);
    dec_valid   = ($urandom_range(0, 9) < 7);
    dec_payload = {$urandom(), $urandom()};
    dec_rs_addr = {6'($urandom_range(0, 12)), 6'($urandom_range(0, 12)), 6'($urandom_range(0, 12))};
    dec_rs_use  = 3'($urandom());
    dec_rd_addr = 6'($urandom_range(0, 12));
    dec_rd_we   = 1'($urandom());
    wb_addr     = 6'($urandom_range(1, 12));
    wb_en       = lk[wb_addr] ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
    wb_data     = {$urandom(), $urandom()};
    ex_ready    = ($urandom_range(0, 9) < 7);
    if ($urandom_range(0, 29) == 0) lk[6'($urandom_range(1, 12))] = 1'b1;
    for (int r = 0; r < NR; r++) regs[r] = {$urandom(), $urandom()};
  endtask

  initial begin
    logic [63:0] wbv;
    m_hv = 1'b0; m_hpay = 64'd0; m_huse = 3'd0; m_hrd = 6'd0; m_hwe = 1'b0;
    for (int n = 0; n < 3; n++) begin m_hrs[n] = 6'd0; m_eop[n] = 64'd0; end
    m_ev = 1'b0; m_epay = 64'd0; m_erd = 6'd0; m_ewe = 1'b0; m_cnt = 32'd0;
    for (int r = 0; r < NR; r++) regs[r] = {$urandom(), $urandom()};
    lk = 64'd0; wb_addr = 6'd0; wb_data = 64'd0; ex_ready = 1'b1;
    idle();

    // Reset with a valid bundle offered: nothing accepted, nothing locked
    rst = 1'b1;
    send(64'hAAAA_0000_0000_0001, 6'd5, 6'd6, 6'd0, 3'b011, 6'd7, 1'b1);
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 64'd0);
    chk("rst_stall_cnt", stall_cnt, 64'd0);
    chk("rst_dec_ready", dec_ready, 64'd0);
    chk("rst_lock_en", wr_lock_en, 64'd0);

    // Independent op: accepted first edge after release, issues next cycle
    rst = 1'b0;
    regs[5] = 64'h11; regs[6] = 64'h22;
    send(64'hAAAA_0000_0000_0001, 6'd5, 6'd6, 6'd0, 3'b011, 6'd7, 1'b1);
    tick();
    idle();
    #1;
    chk("indep_lock_en", wr_lock_en, 64'd1);
    chk("indep_lock_addr", wr_lock_addr, 64'd7);
    tick();
    chk("indep_valid", ex_valid, 64'd1);
    chk("indep_rs1", ex_rs1, 64'h11);
    chk("indep_rs2", ex_rs2, 64'h22);
    chk("indep_rd", ex_rd_addr, 64'd7);

    // RAW stall on a locked rs1 for four cycles, then released by writeback bypass
    lk[5] = 1'b1;
    send(64'hBBBB_0000_0000_0002, 6'd5, 6'd0, 6'd0, 3'b001, 6'd8, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("stall_cnt_4", stall_cnt, 64'd4);
    wb_en = 1'b1; wb_addr = 6'd5; wb_data = 64'hABCD;
    tick();
    chk("bypass_valid", ex_valid, 64'd1);
    chk("bypass_rs1", ex_rs1, 64'hABCD);

    // Back-to-back: leader writes x9, follower reads x9 and waits for its writeback
    idle();
    send(64'hCCCC_0000_0000_0003, 6'd0, 6'd0, 6'd0, 3'b000, 6'd9, 1'b1);
    tick();
    send(64'hDDDD_0000_0000_0004, 6'd9, 6'd0, 6'd0, 3'b001, 6'd10, 1'b1);
    #1;
    chk("b2b_ready", dec_ready, 64'd1);
    tick();
    idle();
    tick(); tick();
    wbv = 64'h5A5A_0000_1234_9999;
    wb_en = 1'b1; wb_addr = 6'd9; wb_data = wbv;
    tick();
    chk("b2b_rs1", ex_rs1, wbv);
    chk("b2b_payload", ex_payload, 64'hDDDD_0000_0000_0004);

    // Execute backpressure: bundle stays put, new instruction waits without locking
    idle();
    ex_ready = 1'b0;
    regs[1] = 64'h77;
    send(64'hEEEE_0000_0000_0005, 6'd1, 6'd0, 6'd0, 3'b001, 6'd11, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_dec_ready", dec_ready, 64'd0);
      chk("bp_lock_en", wr_lock_en, 64'd0);
      tick();
      chk("bp_payload", ex_payload, 64'hDDDD_0000_0000_0004);
      chk("bp_rs1", ex_rs1, wbv);
    end
    ex_ready = 1'b1;
    tick();
    chk("bp_release", ex_payload, 64'hEEEE_0000_0000_0005);

    // Flush while an instruction is held and a bundle is valid
    ex_ready = 1'b0;
    send(64'hFFFF_0000_0000_0006, 6'd2, 6'd0, 6'd0, 3'b001, 6'd12, 1'b1);
    tick();
    idle();
    flush = 1'b1;
    #1;
    chk("flush_lock_en", wr_lock_en, 64'd0);
    tick();
    chk("flush_ex_valid", ex_valid, 64'd0);
    flush = 1'b0;
    #1;
    chk("flush_empty_ready", dec_ready, 64'd1);
    chk("flush_empty_addr", rs1_addr, 64'd0);
    tick();

    // x0 source with its lock bit forced: no stall, operand zero, no lock for rd=x0
    ex_ready = 1'b1;
    lk[0] = 1'b1; regs[0] = 64'hDEAD_BEEF;
    send(64'h1111_0000_0000_0007, 6'd0, 6'd0, 6'd0, 3'b001, 6'd0, 1'b1);
    tick();
    idle();
    #1;
    chk("x0_lock_en", wr_lock_en, 64'd0);
    tick();
    chk("x0_valid", ex_valid, 64'd1);
    chk("x0_rs1", ex_rs1, 64'd0);
    lk[0] = 1'b0;

    // Reset in the cycle an instruction would issue: dropped, never locked
    send(64'h2222_0000_0000_0008, 6'd3, 6'd0, 6'd0, 3'b001, 6'd13, 1'b1);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("mid_rst_lock_en", wr_lock_en, 64'd0);
    tick();
    chk("mid_rst_valid", ex_valid, 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", ex_valid, 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
